// File: rtl/vec_mem_arbiter.sv
// vec_mem_arbiter: 2:1 arbiter that merges the picorv32 CPU memory port and the
// picorv32_pcpi_vec coprocessor memory port onto one shared memory port.
// Each transaction is granted whole, every output is registered, and a hung
// shared-port access is completed by a timeout.
module vec_mem_arbiter #(
  parameter int unsigned ROUND_ROBIN  = 1,
  parameter int unsigned VEC_PRIORITY = 1,
  parameter int unsigned TIMEOUT      = 256
) (
  input  logic        clk,
  input  logic        resetn,
  // CPU master
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  // Vector coprocessor master
  input  logic        vec_mem_valid,
  output logic        vec_mem_ready,
  input  logic [31:0] vec_mem_addr,
  input  logic [31:0] vec_mem_wdata,
  input  logic [3:0]  vec_mem_wstrb,
  output logic [31:0] vec_mem_rdata,
  // Shared memory port
  output logic        ram_mem_valid,
  input  logic        ram_mem_ready,
  output logic [31:0] ram_mem_addr,
  output logic [31:0] ram_mem_wdata,
  output logic [3:0]  ram_mem_wstrb,
  input  logic [31:0] ram_mem_rdata,
  // Sticky timeout flag
  output logic        err_timeout
);

  localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  // Counter value on the last cycle an access may wait before being timed out.
  localparam logic [CntW-1:0] CntLast = (TIMEOUT == 0) ? '0 : CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StResp} state_e;
  typedef enum logic {OwnCpu, OwnVec} owner_e;

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  owner_e          last_q, last_d;
  owner_e          pick;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ram_valid_q, ram_valid_d;
  logic [31:0]     ram_addr_q, ram_addr_d;
  logic [31:0]     ram_wdata_q, ram_wdata_d;
  logic [3:0]      ram_wstrb_q, ram_wstrb_d;
  logic            cpu_ready_q, cpu_ready_d;
  logic [31:0]     cpu_rdata_q, cpu_rdata_d;
  logic            vec_ready_q, vec_ready_d;
  logic [31:0]     vec_rdata_q, vec_rdata_d;
  logic            err_q, err_d;

  // Choose which master would be granted if the arbiter were idle this cycle.
  always_comb begin
    pick = OwnCpu;
    if (mem_valid && vec_mem_valid) begin
      if (ROUND_ROBIN != 0) begin
        pick = (last_q == OwnVec) ? OwnCpu : OwnVec;
      end else begin
        pick = (VEC_PRIORITY != 0) ? OwnVec : OwnCpu;
      end
    end else if (vec_mem_valid) begin
      pick = OwnVec;
    end
  end

  // Next-state logic for the transaction FSM and all registered outputs.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    ram_valid_d = ram_valid_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_wstrb_d = ram_wstrb_q;
    cpu_ready_d = cpu_ready_q;
    cpu_rdata_d = cpu_rdata_q;
    vec_ready_d = vec_ready_q;
    vec_rdata_d = vec_rdata_q;
    err_d       = err_q;

    case (state_q)
      StIdle: begin
        if (mem_valid || vec_mem_valid) begin
          owner_d     = pick;
          last_d      = pick;
          cnt_d       = '0;
          ram_valid_d = 1'b1;
          if (pick == OwnVec) begin
            ram_addr_d  = vec_mem_addr;
            ram_wdata_d = vec_mem_wdata;
            ram_wstrb_d = vec_mem_wstrb;
          end else begin
            ram_addr_d  = mem_addr;
            ram_wdata_d = mem_wdata;
            ram_wstrb_d = mem_wstrb;
          end
          state_d = StGrant;
        end
      end

      StGrant: begin
        if (ram_mem_ready) begin
          // Writes forward whatever the memory drives as well.
          ram_valid_d = 1'b0;
          if (owner_q == OwnVec) begin
            vec_ready_d = 1'b1;
            vec_rdata_d = ram_mem_rdata;
          end else begin
            cpu_ready_d = 1'b1;
            cpu_rdata_d = ram_mem_rdata;
          end
          state_d = StResp;
        end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
          ram_valid_d = 1'b0;
          err_d       = 1'b1;
          if (owner_q == OwnVec) begin
            vec_ready_d = 1'b1;
            vec_rdata_d = '0;
          end else begin
            cpu_ready_d = 1'b1;
            cpu_rdata_d = '0;
          end
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StResp: begin
        cpu_ready_d = 1'b0;
        vec_ready_d = 1'b0;
        state_d     = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      owner_q     <= OwnCpu;
      last_q      <= OwnVec;
      cnt_q       <= '0;
      ram_valid_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_wstrb_q <= '0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      vec_ready_q <= 1'b0;
      vec_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      ram_valid_q <= ram_valid_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_wstrb_q <= ram_wstrb_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      vec_ready_q <= vec_ready_d;
      vec_rdata_q <= vec_rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_ready     = cpu_ready_q;
  assign mem_rdata     = cpu_rdata_q;
  assign vec_mem_ready = vec_ready_q;
  assign vec_mem_rdata = vec_rdata_q;
  assign ram_mem_valid = ram_valid_q;
  assign ram_mem_addr  = ram_addr_q;
  assign ram_mem_wdata = ram_wdata_q;
  assign ram_mem_wstrb = ram_wstrb_q;
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_vec_mem_arbiter.sv
// Bench for vec_mem_arbiter: a round-robin instance and a fixed-priority
// instance, each with its own small word-addressed memory model.
module tb_vec_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        mem_valid, vec_mem_valid;
  logic [31:0] mem_addr, mem_wdata, vec_mem_addr, vec_mem_wdata;
  logic [3:0]  mem_wstrb, vec_mem_wstrb;

  logic        rr_mem_ready, rr_vec_ready, rr_ram_valid, rr_ram_ready, rr_err;
  logic [31:0] rr_mem_rdata, rr_vec_rdata, rr_ram_addr, rr_ram_wdata, rr_ram_rdata;
  logic [3:0]  rr_ram_wstrb;
  logic        fp_mem_ready, fp_vec_ready, fp_ram_valid, fp_ram_ready, fp_err;
  logic [31:0] fp_mem_rdata, fp_vec_rdata, fp_ram_addr, fp_ram_wdata, fp_ram_rdata;
  logic [3:0]  fp_ram_wstrb;

  vec_mem_arbiter #(.ROUND_ROBIN(1), .VEC_PRIORITY(1), .TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_ready(rr_mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(rr_mem_rdata),
    .vec_mem_valid(vec_mem_valid), .vec_mem_ready(rr_vec_ready), .vec_mem_addr(vec_mem_addr),
    .vec_mem_wdata(vec_mem_wdata), .vec_mem_wstrb(vec_mem_wstrb), .vec_mem_rdata(rr_vec_rdata),
    .ram_mem_valid(rr_ram_valid), .ram_mem_ready(rr_ram_ready), .ram_mem_addr(rr_ram_addr),
    .ram_mem_wdata(rr_ram_wdata), .ram_mem_wstrb(rr_ram_wstrb), .ram_mem_rdata(rr_ram_rdata),
    .err_timeout(rr_err)
  );

  vec_mem_arbiter #(.ROUND_ROBIN(0), .VEC_PRIORITY(1), .TIMEOUT(8)) dut_fp (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_ready(fp_mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(fp_mem_rdata),
    .vec_mem_valid(vec_mem_valid), .vec_mem_ready(fp_vec_ready), .vec_mem_addr(vec_mem_addr),
    .vec_mem_wdata(vec_mem_wdata), .vec_mem_wstrb(vec_mem_wstrb), .vec_mem_rdata(fp_vec_rdata),
    .ram_mem_valid(fp_ram_valid), .ram_mem_ready(fp_ram_ready), .ram_mem_addr(fp_ram_addr),
    .ram_mem_wdata(fp_ram_wdata), .ram_mem_wstrb(fp_ram_wstrb), .ram_mem_rdata(fp_ram_rdata),
    .err_timeout(fp_err)
  );

  // Memory models: reply ram_lat+1 cycles after seeing valid; rdata is the
  // word before any write is applied.
  logic [31:0] mem_rr [0:255];
  logic [31:0] mem_fp [0:255];
  logic        ram_on, mdl_ready, extra_ready, fp_mdl_ready;
  int unsigned ram_lat, wait_cnt;

  assign rr_ram_ready = mdl_ready | extra_ready;
  assign fp_ram_ready = fp_mdl_ready;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mdl_ready    <= 1'b0;
      wait_cnt     <= 0;
      rr_ram_rdata <= '0;
    end else begin
      mdl_ready <= 1'b0;
      if (rr_ram_valid && !mdl_ready && ram_on) begin
        if (wait_cnt == ram_lat) begin
          mdl_ready    <= 1'b1;
          wait_cnt     <= 0;
          rr_ram_rdata <= mem_rr[rr_ram_addr[9:2]];
          for (int b = 0; b < 4; b++)
            if (rr_ram_wstrb[b]) mem_rr[rr_ram_addr[9:2]][8*b +: 8] = rr_ram_wdata[8*b +: 8];
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end else begin
        wait_cnt <= 0;
      end
    end
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fp_mdl_ready <= 1'b0;
      fp_ram_rdata <= '0;
    end else begin
      fp_mdl_ready <= fp_ram_valid && !fp_mdl_ready;
      if (fp_ram_valid && !fp_mdl_ready) begin
        fp_ram_rdata <= mem_fp[fp_ram_addr[9:2]];
        for (int b = 0; b < 4; b++)
          if (fp_ram_wstrb[b]) mem_fp[fp_ram_addr[9:2]][8*b +: 8] = fp_ram_wdata[8*b +: 8];
      end
    end
  end

  // Selected instance for the transaction task.
  logic        sel_fp;
  logic        s_cpu_ready, s_vec_ready, s_ram_valid;
  logic [31:0] s_cpu_rdata, s_vec_rdata;
  logic [3:0]  s_ram_wstrb;
  assign s_cpu_ready = sel_fp ? fp_mem_ready : rr_mem_ready;
  assign s_vec_ready = sel_fp ? fp_vec_ready : rr_vec_ready;
  assign s_cpu_rdata = sel_fp ? fp_mem_rdata : rr_mem_rdata;
  assign s_vec_rdata = sel_fp ? fp_vec_rdata : rr_vec_rdata;
  assign s_ram_valid = sel_fp ? fp_ram_valid : rr_ram_valid;
  assign s_ram_wstrb = sel_fp ? fp_ram_wstrb : rr_ram_wstrb;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // The shared address must not move while a grant is outstanding.
  logic [31:0] prev_addr = '0;
  logic        prev_v = 1'b0;
  always @(negedge clk) begin
    if (resetn && prev_v && rr_ram_valid) chk("addr_stable", rr_ram_addr, prev_addr);
    prev_v    = rr_ram_valid;
    prev_addr = rr_ram_addr;
  end

  task automatic do_reset();
    resetn        = 1'b0;
    mem_valid     = 1'b0;
    vec_mem_valid = 1'b0;
    extra_ready   = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // Present one request per master at once and collect the replies.
  task automatic run_pair(input logic creq, input logic [31:0] caddr, input logic [31:0] cwdata,
                          input logic [3:0] cwstrb, input logic vreq, input logic [31:0] vaddr,
                          input logic [31:0] vwdata, input logic [3:0] vwstrb,
                          output int first, output logic [31:0] crd, output logic [31:0] vrd,
                          output logic [3:0] wstrb0, output logic spurious, output logic done);
    logic cdone, vdone, seen;
    int   n;
    first = -1; crd = '0; vrd = '0; wstrb0 = '0; spurious = 1'b0; seen = 1'b0;
    cdone = !creq; vdone = !vreq;
    mem_addr = caddr; mem_wdata = cwdata; mem_wstrb = cwstrb; mem_valid = creq;
    vec_mem_addr = vaddr; vec_mem_wdata = vwdata; vec_mem_wstrb = vwstrb; vec_mem_valid = vreq;
    n = 0;
    while (!(cdone && vdone) && n < 100) begin
      @(negedge clk);
      n++;
      if (s_ram_valid && !seen) begin
        seen   = 1'b1;
        wstrb0 = s_ram_wstrb;
      end
      if (s_cpu_ready) begin
        if (cdone) spurious = 1'b1;
        else begin
          cdone = 1'b1; crd = s_cpu_rdata; mem_valid = 1'b0;
          if (first < 0) first = 0;
        end
      end
      if (s_vec_ready) begin
        if (vdone) spurious = 1'b1;
        else begin
          vdone = 1'b1; vrd = s_vec_rdata; vec_mem_valid = 1'b0;
          if (first < 0) first = 1;
        end
      end
    end
    done = cdone && vdone;
    mem_valid = 1'b0;
    vec_mem_valid = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic        creq;
    logic [31:0] caddr, cwdata;
    logic [3:0]  cwstrb;
    logic        vreq;
    logic [31:0] vaddr, vwdata;
    logic [3:0]  vwstrb;
    int          exp_first;
    logic [31:0] exp_crd, exp_vrd;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int          first, n, vcnt;
    logic [31:0] crd, vrd;
    logic [3:0]  w0;
    logic        sp, dn, got;

    tbl[0] = '{1'b1, 32'h0,  32'h0,        4'h0, 1'b0, 32'h0,  32'h0,        4'h0, 0, 32'h00400113, 32'h0};
    tbl[1] = '{1'b0, 32'h0,  32'h0,        4'h0, 1'b1, 32'h4,  32'h0,        4'h0, 1, 32'h0,        32'h11111111};
    tbl[2] = '{1'b1, 32'h8,  32'h0,        4'h0, 1'b1, 32'hC,  32'h0,        4'h0, 0, 32'h22222222, 32'h33333333};
    tbl[3] = '{1'b1, 32'h10, 32'h0,        4'h0, 1'b1, 32'h0,  32'h0,        4'h0, 0, 32'h44444444, 32'h00400113};
    tbl[4] = '{1'b1, 32'h8,  32'hDEADBEEF, 4'hF, 1'b1, 32'h4,  32'h0,        4'h0, 0, 32'h22222222, 32'h11111111};
    tbl[5] = '{1'b1, 32'h8,  32'h0,        4'h0, 1'b0, 32'h0,  32'h0,        4'h0, 0, 32'hDEADBEEF, 32'h0};
    tbl[6] = '{1'b1, 32'h4,  32'h0,        4'h0, 1'b1, 32'h10, 32'h0,        4'h0, 1, 32'h11111111, 32'h44444444};
    tbl[7] = '{1'b0, 32'h0,  32'h0,        4'h0, 1'b1, 32'hC,  32'h00AB0000, 4'h4, 1, 32'h0,        32'h33333333};
    tbl[8] = '{1'b1, 32'hC,  32'h0,        4'h0, 1'b0, 32'h0,  32'h0,        4'h0, 0, 32'h33AB3333, 32'h0};
    tbl[9] = '{1'b1, 32'h0,  32'h0,        4'h0, 1'b1, 32'h8,  32'h0,        4'h0, 1, 32'h00400113, 32'hDEADBEEF};

    for (int i = 0; i < 256; i++) begin
      mem_rr[i] = '0;
      mem_fp[i] = '0;
    end
    mem_rr[0] = 32'h00400113; mem_rr[1] = 32'h11111111; mem_rr[2] = 32'h22222222;
    mem_rr[3] = 32'h33333333; mem_rr[4] = 32'h44444444;
    mem_fp[0] = 32'h00400113; mem_fp[100] = 32'h12345600;
    ram_on = 1'b1; ram_lat = 0; sel_fp = 1'b0; extra_ready = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    vec_mem_addr = '0; vec_mem_wdata = '0; vec_mem_wstrb = '0;

    // Reset state
    do_reset();
    chk("rst_ram_valid", rr_ram_valid, 0);
    chk("rst_ram_addr", rr_ram_addr, 0);
    chk("rst_ram_wdata", rr_ram_wdata, 0);
    chk("rst_ram_wstrb", rr_ram_wstrb, 0);
    chk("rst_mem_ready", rr_mem_ready, 0);
    chk("rst_vec_ready", rr_vec_ready, 0);
    chk("rst_mem_rdata", rr_mem_rdata, 0);
    chk("rst_err", rr_err, 0);

    // Cycle-exact CPU read with a one-cycle memory
    mem_addr = 32'h0; mem_wstrb = 4'h0; mem_valid = 1'b1;
    @(negedge clk);
    chk("t1_c1_ram_valid", rr_ram_valid, 1);
    chk("t1_c1_ram_addr", rr_ram_addr, 32'h0);
    chk("t1_c1_mem_ready", rr_mem_ready, 0);
    @(negedge clk);
    chk("t1_c2_mem_ready", rr_mem_ready, 0);
    @(negedge clk);
    chk("t1_c3_mem_ready", rr_mem_ready, 1);
    chk("t1_c3_mem_rdata", rr_mem_rdata, 32'h00400113);
    chk("t1_c3_vec_ready", rr_vec_ready, 0);
    mem_valid = 1'b0;
    @(negedge clk);
    chk("t1_c4_mem_ready", rr_mem_ready, 0);
    chk("t1_c4_ram_valid", rr_ram_valid, 0);

    // Round-robin vector table, starting from last_owner = vec
    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_pair(tbl[i].creq, tbl[i].caddr, tbl[i].cwdata, tbl[i].cwstrb,
               tbl[i].vreq, tbl[i].vaddr, tbl[i].vwdata, tbl[i].vwstrb,
               first, crd, vrd, w0, sp, dn);
      chk($sformatf("v%0d_done", i), 32'(dn), 1);
      chk($sformatf("v%0d_first", i), 32'(first), 32'(tbl[i].exp_first));
      chk($sformatf("v%0d_spurious", i), 32'(sp), 0);
      if (tbl[i].creq) chk($sformatf("v%0d_cpu_rdata", i), crd, tbl[i].exp_crd);
      if (tbl[i].vreq) chk($sformatf("v%0d_vec_rdata", i), vrd, tbl[i].exp_vrd);
    end

    // Fixed priority, vec wins the tie; vec does a byte write
    sel_fp = 1'b1;
    do_reset();
    run_pair(1'b1, 32'h0, 32'h0, 4'h0, 1'b1, 32'h190, 32'h000000AB, 4'b0001,
             first, crd, vrd, w0, sp, dn);
    chk("fp_done", 32'(dn), 1);
    chk("fp_first", 32'(first), 1);
    chk("fp_wstrb", 32'(w0), 32'h1);
    chk("fp_mem100", mem_fp[100], 32'h123456AB);
    chk("fp_cpu_rdata", crd, 32'h00400113);
    chk("fp_vec_rdata", vrd, 32'h12345600);
    sel_fp = 1'b0;

    // Timeout: memory never answers
    do_reset();
    ram_on = 1'b0;
    mem_addr = 32'h20; mem_wstrb = 4'h0; mem_valid = 1'b1;
    vcnt = 0; got = 1'b0; n = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (rr_ram_valid) vcnt++;
      if (rr_mem_ready) begin
        got = 1'b1;
        crd = rr_mem_rdata;
      end
    end
    mem_valid = 1'b0;
    chk("to_got_ready", 32'(got), 1);
    chk("to_valid_cycles", 32'(vcnt), 8);
    chk("to_rdata", crd, 32'h0);
    chk("to_err", rr_err, 1);
    @(negedge clk);
    extra_ready = 1'b1;
    @(negedge clk);
    extra_ready = 1'b0;
    @(negedge clk);
    chk("late_mem_ready", rr_mem_ready, 0);
    chk("late_vec_ready", rr_vec_ready, 0);
    chk("late_ram_valid", rr_ram_valid, 0);
    chk("late_err_sticky", rr_err, 1);

    // Reset mid-grant, then the held CPU request restarts
    mem_addr = 32'h0; mem_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_in_grant", rr_ram_valid, 1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_ram_valid", rr_ram_valid, 0);
    chk("mid_rst_ram_addr", rr_ram_addr, 0);
    chk("mid_rst_mem_ready", rr_mem_ready, 0);
    chk("mid_rst_err", rr_err, 0);
    @(negedge clk);
    ram_on = 1'b1; ram_lat = 0;
    resetn = 1'b1;
    got = 1'b0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (rr_mem_ready) begin
        got = 1'b1;
        crd = rr_mem_rdata;
      end
    end
    mem_valid = 1'b0;
    chk("restart_got_ready", 32'(got), 1);
    chk("restart_rdata", crd, 32'h00400113);
    chk("restart_err", rr_err, 0);
    @(negedge clk);

    // Ready on the last allowed cycle completes normally
    ram_lat = 6;
    mem_addr = 32'h4; mem_valid = 1'b1;
    vcnt = 0; got = 1'b0; n = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (rr_ram_valid) vcnt++;
      if (rr_mem_ready) begin
        got = 1'b1;
        crd = rr_mem_rdata;
      end
    end
    mem_valid = 1'b0;
    chk("edge_got_ready", 32'(got), 1);
    chk("edge_valid_cycles", 32'(vcnt), 8);
    chk("edge_rdata", crd, 32'h11111111);
    chk("edge_err", rr_err, 0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
